// File: rtl/trax_pkg.sv
// Shared Trax types and constants: cell/tile encodings, move word layout,
// board size defaults and the scanner state encoding.
package trax_pkg;

  localparam int TRAX_MAX_ROW = 50;
  localparam int TRAX_MAX_COL = 50;
  localparam int TRAX_COORD_W = 10;

  localparam logic [2:0] CELL_EMPTY = 3'b000;

  localparam logic [1:0] TILE_NONE   = 2'b00;
  localparam logic [1:0] TILE_PLUS   = 2'b01;
  localparam logic [1:0] TILE_SLASH  = 2'b10;
  localparam logic [1:0] TILE_BSLASH = 2'b11;

  // One entry of the move list, MSB first: tile, column, row.
  typedef struct packed {
    logic [1:0]              tile;
    logic [TRAX_COORD_W-1:0] col;
    logic [TRAX_COORD_W-1:0] row;
  } move_t;

  typedef enum logic [3:0] {
    ST_IDLE,
    ST_RD_CTR,
    ST_RD_UP,
    ST_RD_DN,
    ST_RD_LF,
    ST_RD_RT,
    ST_EVAL,
    ST_EMIT,
    ST_NEXT,
    ST_DONE
  } scan_state_t;

endpackage

// File: rtl/valid_move_rule.sv
// Neighbour-adjacency rule for one empty cell: maps the occupied-neighbour
// mask {up, right, down, left} to the candidate tiles in emit order.
module valid_move_rule
  import trax_pkg::*;
(
  input  logic [3:0] mask,
  output logic [1:0] cnt,
  output logic [1:0] tile0,
  output logic [1:0] tile1,
  output logic [1:0] tile2
);

  // Decode the mask; anything other than one or two neighbours yields no move.
  always_comb begin
    cnt   = 2'd0;
    tile0 = TILE_NONE;
    tile1 = TILE_NONE;
    tile2 = TILE_NONE;
    case (mask)
      4'b1000, 4'b0100, 4'b0010, 4'b0001: begin
        cnt = 2'd3; tile0 = TILE_PLUS; tile1 = TILE_SLASH; tile2 = TILE_BSLASH;
      end
      4'b1100: begin cnt = 2'd2; tile0 = TILE_PLUS;   tile1 = TILE_SLASH;  end
      4'b1010: begin cnt = 2'd2; tile0 = TILE_BSLASH; tile1 = TILE_SLASH;  end
      4'b1001: begin cnt = 2'd2; tile0 = TILE_PLUS;   tile1 = TILE_BSLASH; end
      4'b0110: begin cnt = 2'd2; tile0 = TILE_PLUS;   tile1 = TILE_BSLASH; end
      4'b0101: begin cnt = 2'd2; tile0 = TILE_BSLASH; tile1 = TILE_SLASH;  end
      4'b0011: begin cnt = 2'd2; tile0 = TILE_PLUS;   tile1 = TILE_SLASH;  end
      default: ;
    endcase
  end

endmodule

// File: rtl/valid_move_scanner.sv
// Sequential valid-move scanner: walks the board through a 1-cycle-latency
// read port and writes every legal move into the move-list RAM.
// Optional region-of-interest scan is enabled by defining VALID_MOVE_ROI_EN.
module valid_move_scanner
  import trax_pkg::*;
#(
  parameter int MAX_ROW   = TRAX_MAX_ROW,
  parameter int MAX_COL   = TRAX_MAX_COL,
  parameter int COORD_W   = TRAX_COORD_W,
  parameter int MAX_MOVES = 203,
  parameter int K_W       = 8
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   start,
  input  logic [COORD_W-1:0]     m,
  input  logic [COORD_W-1:0]     n,
`ifdef VALID_MOVE_ROI_EN
  input  logic [COORD_W-1:0]     roi_r0,
  input  logic [COORD_W-1:0]     roi_r1,
  input  logic [COORD_W-1:0]     roi_c0,
  input  logic [COORD_W-1:0]     roi_c1,
`endif
  output logic                   rd_en,
  output logic [COORD_W-1:0]     rd_row,
  output logic [COORD_W-1:0]     rd_col,
  input  logic [2:0]             rd_data,
  output logic                   mv_we,
  output logic [K_W-1:0]         mv_addr,
  output logic [2+2*COORD_W-1:0] mv_data,
  output logic [K_W-1:0]         k,
  output logic                   busy,
  output logic                   done,
  output logic                   overflow
);

  localparam logic [COORD_W-1:0] ONE       = COORD_W'(1);
  localparam logic [COORD_W-1:0] MAX_ROW_C = COORD_W'(MAX_ROW);
  localparam logic [COORD_W-1:0] MAX_COL_C = COORD_W'(MAX_COL);
  localparam logic [K_W-1:0]     K_MAX     = K_W'(MAX_MOVES);
  localparam logic [K_W-1:0]     K_ONE     = K_W'(1);

  scan_state_t              state_reg;
  logic [COORD_W-1:0]       nn_reg, mm_reg, r_reg, c_reg;
  logic [COORD_W-1:0]       r_hi_reg, c_lo_reg, c_hi_reg;
  logic [K_W-1:0]           k_reg, mv_addr_reg;
  logic                     overflow_reg, busy_reg, done_reg, rd_en_reg, mv_we_reg;
  logic [COORD_W-1:0]       rd_row_reg, rd_col_reg;
  logic [2+2*COORD_W-1:0]   mv_data_reg;
  logic                     up_reg, dn_reg, lf_reg;
  logic [1:0]               cnt_reg, emit_idx_reg;
  logic [3:0][1:0]          tiles_reg;

  logic [COORD_W-1:0] nn_in, mm_in, r_lo, r_hi, c_lo, c_hi;
  logic               scan_empty;
  logic               up_ok, dn_ok, lf_ok, rt_ok, cell_hit;
  logic               col_wrap, last_cell;
  logic [COORD_W-1:0] nr, nc;
  logic [1:0]         rule_cnt, rule_t0, rule_t1, rule_t2;

  // Scan bounds for a new start: board clipped to the supported size, then to the ROI.
  always_comb begin
    nn_in = (n > MAX_ROW_C) ? MAX_ROW_C : n;
    mm_in = (m > MAX_COL_C) ? MAX_COL_C : m;
`ifdef VALID_MOVE_ROI_EN
    r_lo = roi_r0;
    c_lo = roi_c0;
    r_hi = (roi_r1 < nn_in - ONE) ? roi_r1 : nn_in - ONE;
    c_hi = (roi_c1 < mm_in - ONE) ? roi_c1 : mm_in - ONE;
    scan_empty = (nn_in == '0) || (mm_in == '0) || (r_lo > r_hi) || (c_lo > c_hi);
`else
    r_lo = '0;
    c_lo = '0;
    r_hi = nn_in - ONE;
    c_hi = mm_in - ONE;
    scan_empty = (nn_in == '0) || (mm_in == '0);
`endif
  end

  // Board-edge tests always use the full board, never the ROI.
  assign up_ok    = (r_reg != '0);
  assign dn_ok    = (r_reg != nn_reg - ONE);
  assign lf_ok    = (c_reg != '0);
  assign rt_ok    = (c_reg != mm_reg - ONE);
  assign cell_hit = (rd_data != CELL_EMPTY);

  assign col_wrap  = (c_reg == c_hi_reg);
  assign last_cell = col_wrap && (r_reg == r_hi_reg);
  assign nr        = col_wrap ? r_reg + ONE : r_reg;
  assign nc        = col_wrap ? c_lo_reg : c_reg + ONE;

  // Right-neighbour data arrives in EVAL, so it feeds the rule directly.
  valid_move_rule u_rule (
    .mask  ({up_reg, rt_ok & cell_hit, dn_reg, lf_reg}),
    .cnt   (rule_cnt),
    .tile0 (rule_t0),
    .tile1 (rule_t1),
    .tile2 (rule_t2)
  );

  // Scan FSM with all bus outputs registered; one cell visited per pass.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_reg    <= ST_IDLE;
      nn_reg       <= '0;
      mm_reg       <= '0;
      r_reg        <= '0;
      c_reg        <= '0;
      r_hi_reg     <= '0;
      c_lo_reg     <= '0;
      c_hi_reg     <= '0;
      k_reg        <= '0;
      overflow_reg <= 1'b0;
      busy_reg     <= 1'b0;
      done_reg     <= 1'b0;
      rd_en_reg    <= 1'b0;
      rd_row_reg   <= '0;
      rd_col_reg   <= '0;
      mv_we_reg    <= 1'b0;
      mv_addr_reg  <= '0;
      mv_data_reg  <= '0;
      up_reg       <= 1'b0;
      dn_reg       <= 1'b0;
      lf_reg       <= 1'b0;
      cnt_reg      <= '0;
      emit_idx_reg <= '0;
      tiles_reg    <= '0;
    end else begin
      done_reg  <= 1'b0;
      rd_en_reg <= 1'b0;
      mv_we_reg <= 1'b0;
      case (state_reg)
        ST_IDLE: begin
          if (start) begin
            nn_reg       <= nn_in;
            mm_reg       <= mm_in;
            r_hi_reg     <= r_hi;
            c_lo_reg     <= c_lo;
            c_hi_reg     <= c_hi;
            r_reg        <= r_lo;
            c_reg        <= c_lo;
            k_reg        <= '0;
            overflow_reg <= 1'b0;
            if (scan_empty) begin
              state_reg <= ST_DONE;
              done_reg  <= 1'b1;
              busy_reg  <= 1'b0;
            end else begin
              state_reg  <= ST_RD_CTR;
              busy_reg   <= 1'b1;
              rd_en_reg  <= 1'b1;
              rd_row_reg <= r_lo;
              rd_col_reg <= c_lo;
            end
          end
        end
        ST_RD_CTR: begin
          state_reg  <= ST_RD_UP;
          rd_en_reg  <= up_ok;
          rd_row_reg <= up_ok ? r_reg - ONE : r_reg;
          rd_col_reg <= c_reg;
        end
        ST_RD_UP: begin
          if (cell_hit) begin
            state_reg <= ST_NEXT;
          end else begin
            state_reg  <= ST_RD_DN;
            rd_en_reg  <= dn_ok;
            rd_row_reg <= dn_ok ? r_reg + ONE : r_reg;
          end
        end
        ST_RD_DN: begin
          up_reg     <= up_ok & cell_hit;
          state_reg  <= ST_RD_LF;
          rd_en_reg  <= lf_ok;
          rd_row_reg <= r_reg;
          rd_col_reg <= lf_ok ? c_reg - ONE : c_reg;
        end
        ST_RD_LF: begin
          dn_reg     <= dn_ok & cell_hit;
          state_reg  <= ST_RD_RT;
          rd_en_reg  <= rt_ok;
          rd_col_reg <= rt_ok ? c_reg + ONE : c_reg;
        end
        ST_RD_RT: begin
          lf_reg     <= lf_ok & cell_hit;
          rd_col_reg <= c_reg;
          state_reg  <= ST_EVAL;
        end
        ST_EVAL: begin
          cnt_reg      <= rule_cnt;
          tiles_reg    <= {TILE_NONE, rule_t2, rule_t1, rule_t0};
          emit_idx_reg <= '0;
          state_reg    <= ST_EMIT;
        end
        ST_EMIT: begin
          if (emit_idx_reg < cnt_reg) begin
            if (k_reg == K_MAX) begin
              overflow_reg <= 1'b1;
              state_reg    <= ST_DONE;
              done_reg     <= 1'b1;
              busy_reg     <= 1'b0;
            end else begin
              mv_we_reg    <= 1'b1;
              mv_addr_reg  <= k_reg;
              mv_data_reg  <= {tiles_reg[emit_idx_reg], c_reg, r_reg};
              k_reg        <= k_reg + K_ONE;
              emit_idx_reg <= emit_idx_reg + 2'd1;
            end
          end else begin
            state_reg <= ST_NEXT;
          end
        end
        ST_NEXT: begin
          if (last_cell) begin
            state_reg <= ST_DONE;
            done_reg  <= 1'b1;
            busy_reg  <= 1'b0;
          end else begin
            r_reg      <= nr;
            c_reg      <= nc;
            state_reg  <= ST_RD_CTR;
            rd_en_reg  <= 1'b1;
            rd_row_reg <= nr;
            rd_col_reg <= nc;
          end
        end
        ST_DONE:  state_reg <= ST_IDLE;
        default:  state_reg <= ST_IDLE;
      endcase
    end
  end

  // The up-neighbour read shares its cycle with the centre data; an occupied
  // centre must not produce any neighbour read, so that one strobe is gated here.
  assign rd_en    = rd_en_reg & ~((state_reg == ST_RD_UP) & cell_hit);
  assign rd_row   = rd_row_reg;
  assign rd_col   = rd_col_reg;
  assign mv_we    = mv_we_reg;
  assign mv_addr  = mv_addr_reg;
  assign mv_data  = mv_data_reg;
  assign k        = k_reg;
  assign busy     = busy_reg;
  assign done     = done_reg;
  assign overflow = overflow_reg;

endmodule

// File: tb/tb_valid_move_scanner.sv
// Directed bench for valid_move_scanner: a default instance plus a
// MAX_MOVES=4 instance share one board model. The ROI scenario is built
// only when VALID_MOVE_ROI_EN is defined.
module tb_valid_move_scanner;
  import trax_pkg::*;

  localparam int CW = 10;
  localparam int KW = 8;
  localparam int DW = 2 + 2 * CW;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          start_a = 1'b0, start_b = 1'b0;
  logic [CW-1:0] m = '0, n = '0;
`ifdef VALID_MOVE_ROI_EN
  logic [CW-1:0] roi_r0 = '0, roi_r1 = '1, roi_c0 = '0, roi_c1 = '1;
`endif

  logic          rd_en_a, rd_en_b, mv_we_a, mv_we_b;
  logic [CW-1:0] rd_row_a, rd_col_a, rd_row_b, rd_col_b;
  logic [2:0]    rd_data_a = 3'b000, rd_data_b = 3'b000;
  logic [KW-1:0] mv_addr_a, mv_addr_b, k_a, k_b;
  logic [DW-1:0] mv_data_a, mv_data_b;
  logic          busy_a, busy_b, done_a, done_b, ovf_a, ovf_b;

  logic [2:0] board [0:7][0:7];

  logic [DW-1:0] wr_data_q[$];
  logic [KW-1:0] wr_addr_q[$];
  logic [DW-1:0] exp_q[$];
  int rd_cnt_a = 0, rd_bad_a = 0, done_cnt_a = 0, done_cnt_b = 0;
  int n_checks = 0, n_fail = 0;
  int wbase, rbase, bbase, dbase_a, dbase_b, lat;

  always #5 clk = ~clk;

  valid_move_scanner u_dut (
    .clk(clk), .rst_n(rst_n), .start(start_a), .m(m), .n(n),
`ifdef VALID_MOVE_ROI_EN
    .roi_r0(roi_r0), .roi_r1(roi_r1), .roi_c0(roi_c0), .roi_c1(roi_c1),
`endif
    .rd_en(rd_en_a), .rd_row(rd_row_a), .rd_col(rd_col_a), .rd_data(rd_data_a),
    .mv_we(mv_we_a), .mv_addr(mv_addr_a), .mv_data(mv_data_a), .k(k_a),
    .busy(busy_a), .done(done_a), .overflow(ovf_a)
  );

  valid_move_scanner #(.MAX_MOVES(4)) u_dut4 (
    .clk(clk), .rst_n(rst_n), .start(start_b), .m(m), .n(n),
`ifdef VALID_MOVE_ROI_EN
    .roi_r0(roi_r0), .roi_r1(roi_r1), .roi_c0(roi_c0), .roi_c1(roi_c1),
`endif
    .rd_en(rd_en_b), .rd_row(rd_row_b), .rd_col(rd_col_b), .rd_data(rd_data_b),
    .mv_we(mv_we_b), .mv_addr(mv_addr_b), .mv_data(mv_data_b), .k(k_b),
    .busy(busy_b), .done(done_b), .overflow(ovf_b)
  );

  function automatic logic [2:0] cell_at(input logic [CW-1:0] r, input logic [CW-1:0] c);
    if (r < 8 && c < 8) return board[r[2:0]][c[2:0]];
    return 3'b000;
  endfunction

  // Board read port with one cycle of latency.
  always @(posedge clk) begin
    rd_data_a <= rd_en_a ? cell_at(rd_row_a, rd_col_a) : 3'b000;
    rd_data_b <= rd_en_b ? cell_at(rd_row_b, rd_col_b) : 3'b000;
  end

  // Record move writes, reads and done pulses of both instances.
  always @(negedge clk) begin
    if (mv_we_a) begin
      wr_addr_q.push_back(mv_addr_a);
      wr_data_q.push_back(mv_data_a);
      $display("write a: addr=%0d tile=%0d col=%0d row=%0d", mv_addr_a,
               mv_data_a[DW-1:DW-2], mv_data_a[2*CW-1:CW], mv_data_a[CW-1:0]);
    end
    if (mv_we_b) begin
      wr_addr_q.push_back(mv_addr_b);
      wr_data_q.push_back(mv_data_b);
      $display("write b: addr=%0d tile=%0d col=%0d row=%0d", mv_addr_b,
               mv_data_b[DW-1:DW-2], mv_data_b[2*CW-1:CW], mv_data_b[CW-1:0]);
    end
    if (rd_en_a) begin
      rd_cnt_a <= rd_cnt_a + 1;
      if (rd_row_a > 2 || rd_col_a > 4) rd_bad_a <= rd_bad_a + 1;
    end
    if (done_a) begin
      done_cnt_a <= done_cnt_a + 1;
      $display("done a: k=%0d overflow=%0d", k_a, ovf_a);
    end
    if (done_b) begin
      done_cnt_b <= done_cnt_b + 1;
      $display("done b: k=%0d overflow=%0d", k_b, ovf_b);
    end
  end

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h", tag, got, exp);
    end
  endtask

  task automatic clear_board();
    for (int r = 0; r < 8; r++)
      for (int c = 0; c < 8; c++)
        board[r][c] = 3'b000;
  endtask

  function automatic logic [DW-1:0] mv(input int r, input int c, input logic [1:0] t);
    move_t w;
    w.tile = t;
    w.col  = CW'(c);
    w.row  = CW'(r);
    return w;
  endfunction

  task automatic add3(input int r, input int c);
    exp_q.push_back(mv(r, c, TILE_PLUS));
    exp_q.push_back(mv(r, c, TILE_SLASH));
    exp_q.push_back(mv(r, c, TILE_BSLASH));
  endtask

  task automatic snapshot();
    wbase   = wr_data_q.size();
    rbase   = rd_cnt_a;
    bbase   = rd_bad_a;
    dbase_a = done_cnt_a;
    dbase_b = done_cnt_b;
  endtask

  task automatic verify_moves(input string tag);
    check_eq({tag, "_nwrites"}, 32'(wr_data_q.size() - wbase), 32'(exp_q.size()));
    for (int i = 0; i < exp_q.size(); i++) begin
      if (wbase + i < wr_data_q.size()) begin
        check_eq($sformatf("%s_addr%0d", tag, i), 32'(wr_addr_q[wbase + i]), 32'(i));
        check_eq($sformatf("%s_data%0d", tag, i), 32'(wr_data_q[wbase + i]), 32'(exp_q[i]));
      end
    end
  endtask

  // Pulse (or hold) start on one instance and wait, bounded, for its done.
  task automatic run_scan(input bit use_b, input int rows, input int cols,
                          input bit hold, input string tag, output int latency);
    bit seen = 1'b0;
    latency = -1;
    n = CW'(rows);
    m = CW'(cols);
    @(negedge clk);
    if (use_b) start_b = 1'b1; else start_a = 1'b1;
    @(negedge clk);
    if (!hold) begin start_a = 1'b0; start_b = 1'b0; end
    for (int i = 0; i < 4000; i++) begin
      if (use_b ? done_b : done_a) begin seen = 1'b1; latency = i; break; end
      @(negedge clk);
    end
    start_a = 1'b0;
    start_b = 1'b0;
    check_eq({tag, "_done_seen"}, 32'(seen), 32'd1);
    repeat (3) @(negedge clk);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not complete");
    $fatal(1, "watchdog");
  end

  initial begin
    clear_board();
    repeat (3) @(negedge clk);
    check_eq("reset_flags", 32'({rd_en_a, mv_we_a, busy_a, done_a, ovf_a}), 32'd0);
    check_eq("reset_k", 32'(k_a), 32'd0);
    check_eq("reset_bus", 32'({rd_row_a, rd_col_a, mv_addr_a}), 32'd0);
    check_eq("reset_mv_data", 32'(mv_data_a), 32'd0);
    rst_n = 1'b1;
    @(negedge clk);

    // Abort during RD_UP, then restart: 3x3 board, single tile at (1,1).
    board[1][1] = 3'b001;
    n = 3; m = 3;
    @(negedge clk); start_a = 1'b1;
    @(negedge clk); start_a = 1'b0;
    @(negedge clk);
    check_eq("busy_mid_scan", 32'(busy_a), 32'd1);
    snapshot();
    rst_n = 1'b0;
    @(negedge clk);
    check_eq("abort_busy", 32'(busy_a), 32'd0);
    check_eq("abort_k", 32'(k_a), 32'd0);
    check_eq("abort_we", 32'(mv_we_a), 32'd0);
    check_eq("abort_rd_en", 32'(rd_en_a), 32'd0);
    rst_n = 1'b1;
    repeat (4) @(negedge clk);
    check_eq("abort_no_writes", 32'(wr_data_q.size() - wbase), 32'd0);

    exp_q.delete();
    add3(0, 1); add3(1, 0); add3(1, 2); add3(2, 1);
    snapshot();
    run_scan(1'b0, 3, 3, 1'b0, "single", lat);
    check_eq("single_k", 32'(k_a), 32'd12);
    check_eq("single_ovf", 32'(ovf_a), 32'd0);
    check_eq("single_busy_after", 32'(busy_a), 32'd0);
    check_eq("single_reads", 32'(rd_cnt_a - rbase), 32'd29);
    check_eq("single_done_cnt", 32'(done_cnt_a - dbase_a), 32'd1);
    verify_moves("single");

    // Tiles at (0,1) and (1,2): two-neighbour cells and edge cells.
    clear_board();
    board[0][1] = 3'b010;
    board[1][2] = 3'b011;
    exp_q.delete();
    add3(0, 0);
    exp_q.push_back(mv(0, 2, TILE_PLUS)); exp_q.push_back(mv(0, 2, TILE_SLASH));
    exp_q.push_back(mv(1, 1, TILE_PLUS)); exp_q.push_back(mv(1, 1, TILE_SLASH));
    add3(2, 2);
    snapshot();
    run_scan(1'b0, 3, 3, 1'b0, "pair", lat);
    check_eq("pair_k", 32'(k_a), 32'd10);
    check_eq("pair_reads", 32'(rd_cnt_a - rbase), 32'd27);
    verify_moves("pair");

    // Tiles at (0,1) and (2,1), start held high through the whole scan.
    clear_board();
    board[0][1] = 3'b001;
    board[2][1] = 3'b100;
    exp_q.delete();
    add3(0, 0); add3(0, 2);
    exp_q.push_back(mv(1, 1, TILE_BSLASH)); exp_q.push_back(mv(1, 1, TILE_SLASH));
    add3(2, 0); add3(2, 2);
    snapshot();
    run_scan(1'b0, 3, 3, 1'b1, "held", lat);
    repeat (5) @(negedge clk);
    check_eq("held_k", 32'(k_a), 32'd14);
    check_eq("held_done_cnt", 32'(done_cnt_a - dbase_a), 32'd1);
    check_eq("held_busy_after", 32'(busy_a), 32'd0);
    check_eq("held_reads", 32'(rd_cnt_a - rbase), 32'd27);
    verify_moves("held");

    // Empty board dimensions: done right after start, nothing accessed.
    snapshot();
    run_scan(1'b0, 0, 0, 1'b0, "empty", lat);
    check_eq("empty_latency", 32'(lat), 32'd0);
    check_eq("empty_k", 32'(k_a), 32'd0);
    check_eq("empty_reads", 32'(rd_cnt_a - rbase), 32'd0);
    check_eq("empty_writes", 32'(wr_data_q.size() - wbase), 32'd0);

    // Capacity 4 with 6 candidates on a 1x3 board.
    clear_board();
    board[0][1] = 3'b001;
    exp_q.delete();
    add3(0, 0);
    exp_q.push_back(mv(0, 2, TILE_PLUS));
    snapshot();
    run_scan(1'b1, 1, 3, 1'b0, "ovf", lat);
    check_eq("ovf_flag", 32'(ovf_b), 32'd1);
    check_eq("ovf_k", 32'(k_b), 32'd4);
    check_eq("ovf_done_cnt", 32'(done_cnt_b - dbase_b), 32'd1);
    verify_moves("ovf");

    // A new start clears the sticky overflow.
    run_scan(1'b1, 0, 0, 1'b0, "ovf_clear", lat);
    check_eq("ovf_cleared", 32'(ovf_b), 32'd0);
    check_eq("ovf_clear_k", 32'(k_b), 32'd0);

`ifdef VALID_MOVE_ROI_EN
    // 5x5 board, ROI row 1, cols 1..3.
    clear_board();
    board[0][2] = 3'b001;
    board[2][3] = 3'b001;
    roi_r0 = 1; roi_r1 = 1; roi_c0 = 1; roi_c1 = 3;
    exp_q.delete();
    add3(1, 2); add3(1, 3);
    snapshot();
    run_scan(1'b0, 5, 5, 1'b0, "roi", lat);
    check_eq("roi_k", 32'(k_a), 32'd6);
    check_eq("roi_out_of_range_reads", 32'(rd_bad_a - bbase), 32'd0);
    verify_moves("roi");

    // Inverted ROI finishes immediately with no moves.
    roi_r0 = 2; roi_r1 = 1;
    snapshot();
    run_scan(1'b0, 5, 5, 1'b0, "roi_inv", lat);
    check_eq("roi_inv_latency", 32'(lat), 32'd0);
    check_eq("roi_inv_k", 32'(k_a), 32'd0);
    check_eq("roi_inv_reads", 32'(rd_cnt_a - rbase), 32'd0);
    roi_r0 = '0; roi_r1 = '1; roi_c0 = '0; roi_c1 = '1;
`endif

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
